reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//   Receives the raw board/bench reset and produces ordered, clock-synchronous
//   resets for the SoC. Async assert, sync deassert. Waits for clock lock, then
//   holds for a fixed time. Releases peripherals (bus, UART, timer) first and
//   the CPU core CPU_DELAY cycles later. Supports a software-requested warm reset.
// PARAMETERS
//   SYNC_STAGES  2   flops in the reset_n and pll_locked synchronisers (>=2)
//   HOLD_CYCLES  16  cycles spent in HOLD after lock, before periph release (>=1)
//   CPU_DELAY    4   cycles between periph release and cpu release (>=1)
//   CNT_WIDTH    8   counter width; HOLD_CYCLES and CPU_DELAY must be < 2**CNT_WIDTH
// PORTS
//   clock         in   1  system clock, rising edge
//   reset_n       in   1  raw reset; asynchronous, active-low
//   pll_locked    in   1  clock-generator lock; asynchronous, level
//   sw_reset_req  in   1  one-cycle warm-reset request from CPU/debug, clock domain
//   periph_reset  out  1  active-high reset to bus and peripherals
//   cpu_reset     out  1  active-high reset to CPU core
//   reset_done    out  1  high only in RUN
//   state_o       out  2  current FSM state, for debug/LED
// BEHAVIOUR
//   - reset_n low: all synchroniser flops, FSM and counter are cleared
//     asynchronously. State=ASSERT, cnt=0, periph_reset=1, cpu_reset=1,
//     reset_done=0, state_o=2'd0. No clock edge is required.
//   - rst_sync: SYNC_STAGES-flop chain shifting in 0s. It is set to 1
//     asynchronously by reset_n. It deasserts on the SYNC_STAGES-th rising edge
//     after reset_n goes high.
//   - lock_sync: SYNC_STAGES-flop synchroniser of pll_locked, cleared by reset_n.
//   - FSM (state_o encoding 0..3), all registered:
//       ASSERT(0): cnt=0. Go to HOLD when !rst_sync && lock_sync.
//       HOLD(1):   cnt++ each cycle. At cnt==HOLD_CYCLES-1 go to PERIPH with
//                  cnt=0. HOLD therefore lasts exactly HOLD_CYCLES cycles.
//       PERIPH(2): cnt++ each cycle. At cnt==CPU_DELAY-1 go to RUN. PERIPH
//                  lasts exactly CPU_DELAY cycles.
//       RUN(3):    stays in RUN until an abort.
//   - Abort: if !lock_sync in HOLD, PERIPH or RUN, go to ASSERT next edge, cnt=0.
//   - sw_reset_req: honoured only in RUN; go to ASSERT next edge. Ignored in all
//     other states. With lock held, ASSERT then lasts 1 cycle and the full
//     HOLD/PERIPH sequence replays.
//   - Simultaneous lock loss and sw_reset_req: both go to ASSERT; no difference.
//   - Outputs are decoded from the state register only (glitch-free, no combinational
//     path from inputs):
//       periph_reset = (state==ASSERT || state==HOLD)
//       cpu_reset    = (state!=RUN)
//       reset_done   = (state==RUN)
//   - Invariant: cpu_reset is never 0 while periph_reset is 1.
//   - reset_n low at any time, including mid-HOLD/PERIPH/RUN: immediate async
//     return to the reset values above.
//   - Latency with pll_locked already stable high, counting edges from the first
//     rising edge after reset_n goes high:
//       periph_reset falls after edge SYNC_STAGES+1+HOLD_CYCLES
//       cpu_reset falls CPU_DELAY edges later
//   - Counter never wraps: it is cleared on every state entry and compared
//     against a bound < 2**CNT_WIDTH.
// TESTING
//   1 Default params, pll_locked=1, reset_n low 25ns then high:
//     -> periph_reset falls after edge 19, cpu_reset after edge 23;
//        reset_done=1 and state_o=3 from edge 23.
//   2 reset_n low mid-HOLD (e.g. after edge 10), between clock edges:
//     -> all outputs return to reset values with no clock edge; sequence restarts
//        from edge 1 on release.
//   3 pll_locked=0 at reset release, raised at edge 30:
//     -> stays in ASSERT; enters HOLD at edge 33; periph_reset falls after edge 49.
//   4 In RUN, one-cycle sw_reset_req:
//     -> ASSERT next edge (both resets=1); periph_reset falls 1+16 edges later;
//        cpu_reset falls 4 edges after that.
//   5 pll_locked dropped during PERIPH; separately sw_reset_req pulsed in HOLD:
//     -> lock loss gives ASSERT after 2 sync edges plus 1;
//        the HOLD-state request causes no state change.
//   6 Randomised reset_n/pll_locked/sw_reset_req with an assertion monitor:
//     -> never (!cpu_reset && periph_reset); HOLD always exactly HOLD_CYCLES cycles.

Source files
------------

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered SoC reset release: sync, lock wait, hold, periph then cpu
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CPU_DELAY   = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic       reset_done,
    output logic [1:0] state_o
);

    localparam logic [1:0] ST_ASSERT = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_PERIPH = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CPU_LAST  = CNT_WIDTH'(CPU_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] rst_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_d;
    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;

    logic rst_sync;
    logic lock_sync;

    // Reset chain is preset by reset_n and drains with zeros: async assert, sync release.
    always_comb begin
        rst_sync_d  = {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    end

    assign rst_sync  = rst_sync_q[SYNC_STAGES-1];
    assign lock_sync = lock_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ASSERT: begin
                cnt_d = '0;
                if (!rst_sync && lock_sync) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!lock_sync) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PERIPH: begin
                if (!lock_sync) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == CPU_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                // Lock loss and a warm-reset request have the same effect.
                if (!lock_sync || sw_reset_req) begin
                    state_d = ST_ASSERT;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q  <= '1;
            lock_sync_q <= '0;
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    // Outputs come straight from the state register so they cannot glitch on input changes.
    assign periph_reset = (state_q == ST_ASSERT) || (state_q == ST_HOLD);
    assign cpu_reset    = (state_q != ST_RUN);
    assign reset_done   = (state_q == ST_RUN);
    assign state_o      = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized and directed check of reset_sequencer against a timeline model
module tb_reset_sequencer;

    localparam int SYNC = 2;
    localparam int HOLD = 16;
    localparam int CPUD = 4;
    localparam int CW   = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       periph_reset;
    logic       cpu_reset;
    logic       reset_done;
    logic [1:0] state_o;

    reset_sequencer #(
        .SYNC_STAGES(SYNC),
        .HOLD_CYCLES(HOLD),
        .CPU_DELAY  (CPUD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .sw_reset_req(sw_reset_req),
        .periph_reset(periph_reset),
        .cpu_reset   (cpu_reset),
        .reset_done  (reset_done),
        .state_o     (state_o)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: edges of reset_n high, recent pll samples, and age since the sequence started.
    int rst_hi;
    bit lock_q[$];
    bit seq_act;
    int age;

    int prev_st;
    int hold_run;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_state();
        if (!seq_act) return 0;
        if (age < HOLD) return 1;
        if (age < HOLD + CPUD) return 2;
        return 3;
    endfunction

    function automatic bit m_rst_sync();
        return rst_hi < SYNC;
    endfunction

    function automatic bit m_lock();
        if (lock_q.size() >= SYNC) return lock_q[0];
        return 1'b0;
    endfunction

    task automatic model_reset();
        rst_hi = 0;
        lock_q.delete();
        seq_act = 1'b0;
        age = 0;
        prev_st = 0;
        hold_run = 0;
    endtask

    task automatic model_edge();
        bit rs;
        bit ls;
        int st;
        if (!reset_n) begin
            model_reset();
            return;
        end
        rs = m_rst_sync();
        ls = m_lock();
        st = m_state();
        if (seq_act) begin
            if (!ls) seq_act = 1'b0;
            else if (st == 3 && sw_reset_req) seq_act = 1'b0;
            else if (age < HOLD + CPUD) age++;
        end else if (!rs && ls) begin
            seq_act = 1'b1;
            age = 0;
        end
        if (rst_hi < 1000) rst_hi++;
        lock_q.push_back(pll_locked);
        if (lock_q.size() > SYNC) void'(lock_q.pop_front());
    endtask

    task automatic compare_all();
        int ms;
        ms = m_state();
        check_val("state", int'(state_o), ms);
        check_val("periph_reset", int'(periph_reset), int'(ms <= 1));
        check_val("cpu_reset", int'(cpu_reset), int'(ms != 3));
        check_val("reset_done", int'(reset_done), int'(ms == 3));
        check_val("order_inv", int'(!cpu_reset && periph_reset), 0);
        if (state_o == 2'd1) begin
            hold_run = (prev_st == 1) ? hold_run + 1 : 1;
        end else if (prev_st == 1 && state_o == 2'd2) begin
            check_val("hold_len", hold_run, HOLD);
        end
        prev_st = int'(state_o);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic check_async(input string tag);
        check_val({tag, "_state"}, int'(state_o), 0);
        check_val({tag, "_periph"}, int'(periph_reset), 1);
        check_val({tag, "_cpu"}, int'(cpu_reset), 1);
        check_val({tag, "_done"}, int'(reset_done), 0);
    endtask

    task automatic hold_reset(input int n);
        reset_n = 1'b0;
        model_reset();
        repeat (n) cycle();
    endtask

    task automatic measure(input string tag, input int pll_edge, input int exp_hold,
                           input int exp_per, input int exp_cpu);
        int e_hold;
        int e_per;
        int e_cpu;
        e_hold = -1;
        e_per = -1;
        e_cpu = -1;
        reset_n = 1'b1;
        for (int e = 1; e <= 90 && e_cpu < 0; e++) begin
            cycle();
            if (e == pll_edge) pll_locked = 1'b1;
            if (e_hold < 0 && state_o == 2'd1) e_hold = e;
            if (e_per < 0 && !periph_reset) e_per = e;
            if (e_cpu < 0 && !cpu_reset) e_cpu = e;
        end
        check_val({tag, "_hold_edge"}, e_hold, exp_hold);
        check_val({tag, "_periph_edge"}, e_per, exp_per);
        check_val({tag, "_cpu_edge"}, e_cpu, exp_cpu);
        check_val({tag, "_done"}, int'(reset_done), 1);
        check_val({tag, "_state_run"}, int'(state_o), 3);
    endtask

    initial begin
        int n;
        int rlow;
        model_reset();
        #1;
        check_async("por");

        // Lock already stable: periph after edge 19, cpu after edge 23.
        pll_locked = 1'b1;
        hold_reset(2);
        measure("t1", 0, 3, 19, 23);

        // Async reset mid-HOLD without a clock edge, then a clean restart.
        hold_reset(2);
        reset_n = 1'b1;
        repeat (10) cycle();
        check_val("t2_midhold", int'(state_o), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_async("t2_async");
        model_reset();
        repeat (2) cycle();
        measure("t2", 0, 3, 19, 23);

        // Lock arrives late: raised just after edge 30.
        pll_locked = 1'b0;
        hold_reset(2);
        measure("t3", 30, 33, 49, 53);

        // Warm reset from RUN replays the hold/periph sequence.
        sw_reset_req = 1'b1;
        cycle();
        sw_reset_req = 1'b0;
        check_val("t4_assert_state", int'(state_o), 0);
        check_val("t4_assert_periph", int'(periph_reset), 1);
        check_val("t4_assert_cpu", int'(cpu_reset), 1);
        begin
            int e_per;
            int e_cpu;
            e_per = -1;
            e_cpu = -1;
            for (int e = 1; e <= 40 && e_cpu < 0; e++) begin
                cycle();
                if (e_per < 0 && !periph_reset) e_per = e;
                if (e_cpu < 0 && !cpu_reset) e_cpu = e;
            end
            check_val("t4_periph_edge", e_per, 17);
            check_val("t4_cpu_edge", e_cpu, 21);
        end

        // Lock loss during PERIPH, then a request during HOLD that must be ignored.
        pll_locked = 1'b1;
        hold_reset(2);
        reset_n = 1'b1;
        n = 0;
        while (state_o != 2'd2 && n < 40) begin
            cycle();
            n++;
        end
        check_val("t5_reached_periph", int'(state_o), 2);
        pll_locked = 1'b0;
        n = 0;
        while (state_o != 2'd0 && n < 20) begin
            cycle();
            n++;
        end
        check_val("t5_lockloss_edges", n, SYNC + 1);
        pll_locked = 1'b1;
        n = 0;
        while (state_o != 2'd1 && n < 20) begin
            cycle();
            n++;
        end
        check_val("t5_reached_hold", int'(state_o), 1);
        sw_reset_req = 1'b1;
        cycle();
        sw_reset_req = 1'b0;
        check_val("t5_sw_in_hold", int'(state_o), 1);

        // Randomized reset_n / pll_locked / sw_reset_req.
        rlow = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rlow > 0) begin
                rlow--;
                if (rlow == 0) reset_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                #2;
                reset_n = 1'b0;
                #1;
                check_async("rnd_async");
                model_reset();
                rlow = $urandom_range(1, 4);
            end
            if (pll_locked) begin
                if ($urandom_range(0, 149) == 0) pll_locked = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) pll_locked = 1'b1;
            end
            sw_reset_req = ($urandom_range(0, 29) == 0);
            cycle();
        end
        sw_reset_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
